// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage front end: owns the PC, issues one outstanding instruction-memory read at a time,
// and forwards returned words into the instruction queue, with a one-entry hold buffer and branch squash.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic [3:0]  imem_rmask,
   input  logic        imem_resp,
   input  logic [31:0] imem_rdata,
   input  logic        full,
   input  logic        branch,
   input  logic [31:0] br_pc,
   output logic        enq,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_next,
   output logic [1:0]  state_dbg
);

   // Handshakes: a read is requested while imem_rmask==4'hF and imem_addr stays fixed until the
   // cycle imem_resp is high; enq is a push that is only raised when full==0 and branch==0.
   typedef enum logic [1:0] {IDLE, REQ, HOLD, FLUSH} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] req_addr, req_addr_n;
   logic [31:0] hold_inst, hold_inst_n;
   logic [31:0] br_target;
   logic [31:0] req_inc;

   assign br_target = {br_pc[31:2], 2'b00};
   assign req_inc   = req_addr + 32'd4;
   assign imem_addr = req_addr;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         req_addr  <= RESET_PC;
         hold_inst <= 32'd0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         req_addr  <= req_addr_n;
         hold_inst <= hold_inst_n;
      end
   end

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      req_addr_n  = req_addr;
      hold_inst_n = hold_inst;
      imem_rmask  = 4'h0;
      enq         = 1'b0;
      if_inst     = 32'd0;
      if_pc       = 32'd0;
      if_pc_next  = 32'd0;
      case (state)
         IDLE: begin
            state_n = REQ;
            if (branch) begin
               pc_n       = br_target;
               req_addr_n = br_target;
            end else begin
               req_addr_n = pc;
            end
         end
         REQ: begin
            imem_rmask = 4'hF;
            if (branch) begin
               pc_n = br_target;
               // Without a response the old read is still in flight and must be drained first.
               if (imem_resp) req_addr_n = br_target;
               else           state_n    = FLUSH;
            end else if (imem_resp) begin
               pc_n = req_inc;
               if (full) begin
                  hold_inst_n = imem_rdata;
                  state_n     = HOLD;
               end else begin
                  enq        = 1'b1;
                  if_inst    = imem_rdata;
                  if_pc      = req_addr;
                  if_pc_next = req_inc;
                  req_addr_n = req_inc;
               end
            end
         end
         HOLD: begin
            if (branch) begin
               pc_n       = br_target;
               req_addr_n = br_target;
               state_n    = REQ;
            end else if (!full) begin
               enq        = 1'b1;
               if_inst    = hold_inst;
               if_pc      = pc - 32'd4;
               if_pc_next = pc;
               req_addr_n = pc;
               state_n    = REQ;
            end
         end
         FLUSH: begin
            imem_rmask = 4'hF;
            if (branch) pc_n = br_target;
            if (imem_resp) begin
               req_addr_n = branch ? br_target : pc;
               state_n    = REQ;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios with exact cycle expectations, then random traffic
// checked against a program-order model of the expected fetch stream.
module tb_imem_fetch_ctrl;

   localparam logic [31:0] RESET_PC = 32'h6000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic        imem_resp = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        full = 1'b0;
   logic        branch = 1'b0;
   logic [31:0] br_pc = 32'd0;
   logic        enq;
   logic [31:0] if_inst, if_pc, if_pc_next;
   logic [1:0]  state_dbg;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   imem_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata), .full(full), .branch(branch),
      .br_pc(br_pc), .enq(enq), .if_inst(if_inst), .if_pc(if_pc), .if_pc_next(if_pc_next),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h6000_0000: return 32'h0000_0013;
         32'h6000_0004: return 32'h0000_0093;
         32'h6000_0008: return 32'h0000_0113;
         default:       return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle: inputs applied at the falling edge, outputs readable 1 time unit later.
   task automatic step(input logic r, input logic f, input logic b, input logic [31:0] bp);
      @(negedge clk);
      imem_resp  = r && (imem_rmask == 4'hF);
      imem_rdata = imem_resp ? mem_word(imem_addr) : 32'd0;
      full       = f;
      branch     = b;
      br_pc      = bp;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      imem_resp = 1'b0; imem_rdata = 32'd0; full = 1'b0; branch = 1'b0; br_pc = 32'd0;
      #1;
      check("rst_rmask", 32'(imem_rmask), 32'h0);
      check("rst_enq", 32'(enq), 32'h0);
      check("rst_if", if_inst | if_pc | if_pc_next, 32'h0);
      check("rst_addr", imem_addr, RESET_PC);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("idle_rmask", 32'(imem_rmask), 32'h0);
   endtask

   task automatic expect_enq(input string tag, input logic [31:0] pc);
      check({tag, "_enq"}, 32'(enq), 32'h1);
      check({tag, "_inst"}, if_inst, mem_word(pc));
      check({tag, "_pc"}, if_pc, pc);
      check({tag, "_pcn"}, if_pc_next, pc + 32'd4);
   endtask

   initial begin
      logic        r, f, b, prev_pend;
      logic [31:0] bp, prev_addr, head;
      int          enq_cnt, resp_cnt;

      // Back-to-back zero-wait fetch.
      do_reset();
      step(1, 0, 0, 0); expect_enq("t1a", 32'h6000_0000);
      step(1, 0, 0, 0); expect_enq("t1b", 32'h6000_0004);
      step(1, 0, 0, 0); expect_enq("t1c", 32'h6000_0008);

      // Queue full on the second response, then released after three cycles.
      do_reset();
      step(1, 0, 0, 0); expect_enq("t2a", 32'h6000_0000);
      step(1, 1, 0, 0); check("t2_full_enq", 32'(enq), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         check("t2_hold_rmask", 32'(imem_rmask), 32'h0);
         check("t2_hold_enq", 32'(enq), 32'h0);
      end
      step(0, 0, 0, 0); expect_enq("t2b", 32'h6000_0004);
      step(0, 0, 0, 0);
      check("t2_rmask", 32'(imem_rmask), 32'hF);
      check("t2_addr", imem_addr, 32'h6000_0008);

      // Branch with a pending request: the late response is squashed.
      do_reset();
      step(0, 0, 1, 32'h6000_0100); check("t3_br_enq", 32'(enq), 32'h0);
      step(0, 0, 0, 0);
      check("t3_fl_rmask", 32'(imem_rmask), 32'hF);
      check("t3_fl_addr", imem_addr, 32'h6000_0000);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0); check("t3_squash", 32'(enq), 32'h0);
      step(1, 0, 0, 0);
      check("t3_addr", imem_addr, 32'h6000_0100);
      expect_enq("t3", 32'h6000_0100);

      // Branch coincident with a response; target low bits ignored.
      do_reset();
      step(1, 0, 1, 32'h6000_0042); check("t4_enq", 32'(enq), 32'h0);
      step(0, 0, 0, 0);
      check("t4_rmask", 32'(imem_rmask), 32'hF);
      check("t4_addr", imem_addr, 32'h6000_0040);

      // Branch while holding a buffered instruction.
      do_reset();
      step(1, 1, 0, 0);
      step(0, 0, 1, 32'h6000_0200); check("t5_enq", 32'(enq), 32'h0);
      step(1, 0, 0, 0);
      check("t5_addr", imem_addr, 32'h6000_0200);
      expect_enq("t5", 32'h6000_0200);

      // Wraparound of PC arithmetic.
      do_reset();
      step(0, 0, 1, 32'hFFFF_FFFE);
      step(1, 0, 0, 0); check("t7_squash", 32'(enq), 32'h0);
      step(1, 0, 0, 0); expect_enq("t7", 32'hFFFF_FFFC);
      step(0, 0, 0, 0); check("t7_addr", imem_addr, 32'h0);

      // Asynchronous reset in the middle of a fetch.
      do_reset();
      step(1, 0, 0, 0);
      step(1, 0, 0, 0); check("t6_pre_enq", 32'(enq), 32'h1);
      #1 rst = 1'b0;
      #1;
      check("t6_enq", 32'(enq), 32'h0);
      check("t6_rmask", 32'(imem_rmask), 32'h0);
      check("t6_if", if_inst | if_pc | if_pc_next, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_idle", 32'(imem_rmask), 32'h0);
      step(0, 0, 0, 0);
      check("t6_rmask_req", 32'(imem_rmask), 32'hF);
      check("t6_addr", imem_addr, RESET_PC);

      // Random traffic against the program-order model.
      do_reset();
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      prev_pend = 1'b0; prev_addr = 32'd0; enq_cnt = 0; resp_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 9) < 6);
         f = ($urandom_range(0, 2) == 0);
         b = ($urandom_range(0, 11) == 0);
         bp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : (32'h6000_0000 + 32'($urandom_range(0, 1023)));
         step(r, f, b, bp);
         check("rmask_legal", 32'((imem_rmask == 4'h0) || (imem_rmask == 4'hF)), 32'h1);
         check("addr_align", 32'(imem_addr[1:0]), 32'h0);
         if (prev_pend) begin
            check("req_held", 32'(imem_rmask), 32'hF);
            check("addr_held", imem_addr, prev_addr);
         end
         if (enq) begin
            head = exp_q.pop_front();
            check("enq_gate", 32'({full, branch}), 32'h0);
            expect_enq("rnd", head);
            if (imem_rmask == 4'hF) begin
               check("enq_resp", 32'(imem_resp), 32'h1);
               check("enq_addr", imem_addr, head);
            end
            exp_q.push_back(head + 32'd4);
            enq_cnt++;
         end else begin
            check("idle_if", if_inst | if_pc | if_pc_next, 32'h0);
         end
         if (branch) begin
            exp_q.delete();
            exp_q.push_back({br_pc[31:2], 2'b00});
         end
         if (imem_resp) resp_cnt++;
         prev_pend = (imem_rmask == 4'hF) && !imem_resp;
         prev_addr = imem_addr;
      end
      check("enq_le_resp", 32'(enq_cnt <= resp_cnt), 32'h1);
      check("progress", 32'(enq_cnt > 300), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
